// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the counter type shared by the
// VGA raster timing generator and its per-axis counters.
package vga_timing_pkg;

   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int CNT_W = 10;

   typedef logic [CNT_W-1:0] vga_pos_t;

   // True when pos lies in the half-open window [lo, lo+len).
   function automatic logic in_window(input vga_pos_t pos, input int lo, input int len);
      return (int'(pos) >= lo) && (int'(pos) < (lo + len));
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter. wrap, active and sync are
// combinational and describe the position the counter moves to on this edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VIS  = 640,
   parameter int FP   = 16,
   parameter int SYNC = 96,
   parameter int BP   = 48
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     inc,
   output vga_pos_t count,
   output logic     wrap,
   output logic     active,
   output logic     sync
);

   localparam int       TOTAL = VIS + FP + SYNC + BP;
   localparam vga_pos_t LAST  = vga_pos_t'(TOTAL - 1);

   vga_pos_t count_d;
   vga_pos_t count_q;

   // Next position and wrap detection.
   always_comb begin
      count_d = count_q;
      wrap    = 1'b0;
      if (inc) begin
         if (count_q == LAST) begin
            count_d = '0;
            wrap    = 1'b1;
         end else begin
            count_d = count_q + vga_pos_t'(1);
         end
      end else begin
         count_d = count_q;
         wrap    = 1'b0;
      end
   end

   assign active = (int'(count_d) < VIS);
   assign sync   = in_window(count_d, VIS + FP, SYNC);
   assign count  = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, display-area flag, H/V sync and
// line/frame strobes. Define VGA_SYNC_DELAY_EN to delay flag and syncs one pixel.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VIS  = vga_timing_pkg::H_VIS,
   parameter int H_FP   = vga_timing_pkg::H_FP,
   parameter int H_SYNC = vga_timing_pkg::H_SYNC,
   parameter int H_BP   = vga_timing_pkg::H_BP,
   parameter int V_VIS  = vga_timing_pkg::V_VIS,
   parameter int V_FP   = vga_timing_pkg::V_FP,
   parameter int V_SYNC = vga_timing_pkg::V_SYNC,
   parameter int V_BP   = vga_timing_pkg::V_BP,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   output logic [CNT_W-1:0] CounterX,
   output logic [CNT_W-1:0] CounterY,
   output logic             inDisplayArea,
   output logic             vga_h_sync,
   output logic             vga_v_sync,
   output logic             line_tick,
   output logic             frame_tick
);

   localparam int   H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int   V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
   localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

   generate
      if ((H_TOT > (2 ** CNT_W)) || (V_TOT > (2 ** CNT_W))) begin : g_bad_totals
         $error("vga_timing_gen: H or V total exceeds counter range");
      end
   endgenerate

   vga_pos_t x_count, y_count;
   logic     x_wrap, x_active, x_sync;
   logic     y_active, y_sync, y_wrap_unused_s;

   vga_axis_counter #(.VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_x (
      .clk    (clk),
      .reset  (reset),
      .inc    (pix_en),
      .count  (x_count),
      .wrap   (x_wrap),
      .active (x_active),
      .sync   (x_sync)
   );

   vga_axis_counter #(.VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_y (
      .clk    (clk),
      .reset  (reset),
      .inc    (x_wrap),
      .count  (y_count),
      .wrap   (y_wrap_unused_s),
      .active (y_active),
      .sync   (y_sync)
   );

   logic disp_d, disp_q, hs_d, hs_q, vs_d, vs_q, lt_d, lt_q, ft_d, ft_q;

   // Flags track the next position; on idle edges they hold and strobes drop.
   always_comb begin
      disp_d = disp_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      lt_d   = 1'b0;
      ft_d   = 1'b0;
      if (pix_en) begin
         disp_d = x_active & y_active;
         hs_d   = x_sync ? ~SYNC_IDLE : SYNC_IDLE;
         vs_d   = y_sync ? ~SYNC_IDLE : SYNC_IDLE;
         lt_d   = x_wrap;
         ft_d   = x_wrap && (y_count == vga_pos_t'(V_VIS - 1));
      end else begin
         lt_d   = 1'b0;
         ft_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_q <= 1'b0;
         hs_q   <= SYNC_IDLE;
         vs_q   <= SYNC_IDLE;
         lt_q   <= 1'b0;
         ft_q   <= 1'b0;
      end else begin
         disp_q <= disp_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         lt_q   <= lt_d;
         ft_q   <= ft_d;
      end
   end

   assign CounterX   = x_count;
   assign CounterY   = y_count;
   assign line_tick  = lt_q;
   assign frame_tick = ft_q;

`ifdef VGA_SYNC_DELAY_EN
   logic disp_dly_d, disp_dly_q, hs_dly_d, hs_dly_q, vs_dly_d, vs_dly_q;

   // One-pixel pipeline so flag and syncs line up with late-registered RGB.
   always_comb begin
      disp_dly_d = disp_dly_q;
      hs_dly_d   = hs_dly_q;
      vs_dly_d   = vs_dly_q;
      if (pix_en) begin
         disp_dly_d = disp_q;
         hs_dly_d   = hs_q;
         vs_dly_d   = vs_q;
      end else begin
         disp_dly_d = disp_dly_q;
         hs_dly_d   = hs_dly_q;
         vs_dly_d   = vs_dly_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_dly_q <= 1'b0;
         hs_dly_q   <= SYNC_IDLE;
         vs_dly_q   <= SYNC_IDLE;
      end else begin
         disp_dly_q <= disp_dly_d;
         hs_dly_q   <= hs_dly_d;
         vs_dly_q   <= vs_dly_d;
      end
   end

   assign inDisplayArea = disp_dly_q;
   assign vga_h_sync    = hs_dly_q;
   assign vga_v_sync    = vs_dly_q;
`else
   assign inDisplayArea = disp_q;
   assign vga_h_sync    = hs_q;
   assign vga_v_sync    = vs_q;
`endif

endmodule
